// File: rtl/patdet_pkg.sv
// ---------------------------------------------------------------------------
// patdet_pkg
// Shared definitions for the parametrised serial pattern detector:
//   - default maximum pattern length, default pattern and default length
//   - overlap-mode enum used for the latched mode register
//   - lenw(max)    : width needed to hold a length value 0..max
//   - len_mask(len): mask with the low 'len' bits set
// No ports (package).
// ---------------------------------------------------------------------------
package patdet_pkg;

  localparam int         PKG_MAX_LEN     = 8;
  localparam logic [7:0] PKG_DEF_PATTERN = 8'b0001_0010;
  localparam int         PKG_DEF_LEN     = 5;

  // Masks are built at this fixed width and then truncated by the user,
  // so one function serves every MAX_LEN up to 64.
  localparam int MASK_W = 64;

  typedef enum logic {
    MODE_NONOVL = 1'b0,
    MODE_OVL    = 1'b1
  } ovl_mode_e;

  // A length register must be able to hold MAX_LEN itself, hence the +1.
  function automatic int lenw(input int maxLen);
    return $clog2(maxLen) + 1;
  endfunction

  // Low-'len' bits set; zero length gives an all-zero mask.
  function automatic logic [MASK_W-1:0] len_mask(input int len);
    if (len <= 0) begin
      return '0;
    end else if (len >= MASK_W) begin
      return '1;
    end else begin
      return (64'd1 << len) - 64'd1;
    end
  endfunction

endpackage

// File: rtl/patdet_sat_cnt.sv
// ---------------------------------------------------------------------------
// patdet_sat_cnt
// Saturating event counter with a sticky saturation flag.
// Ports:
//   clk      in   clock, posedge
//   rst      in   synchronous active-high reset
//   i_clear  in   synchronous clear of count and flag
//   i_inc    in   increment enable (ignored once the count is all-ones)
//   o_count  out  CNT_W-bit count
//   o_sat    out  sticky flag, set on the cycle the count becomes all-ones
// ---------------------------------------------------------------------------
module patdet_sat_cnt
  import patdet_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count,
  output logic             o_sat
);

  logic [CNT_W-1:0] r_count;
  logic             r_sat;
  logic [CNT_W-1:0] w_countNext;
  logic             w_full;

  assign w_countNext = r_count + 1'b1;
  assign w_full      = &r_count;

  // Count up on each enabled cycle until all-ones, then hold. The sticky
  // flag is raised by the same edge that makes the count all-ones, so it
  // never lags the count. Reset and clear share the same effect.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (i_inc && !w_full) begin
      r_count <= w_countNext;
      if (&w_countNext) begin
        r_sat <= 1'b1;
      end
    end
  end

  assign o_count = r_count;
  assign o_sat   = r_sat;

endmodule

// File: rtl/pattern_detector_param.sv
// ---------------------------------------------------------------------------
// pattern_detector_param
// Serial pattern detector with a run-time programmable pattern of up to
// MAX_LEN bits, overlapping or non-overlapping detection and a registered
// one-cycle match pulse.
// Optional feature macro: PATDET_COUNTER_EN builds the saturating match
// counter; without it match_count and count_sat are tied to zero.
// Ports:
//   clk          in   clock, posedge
//   rst          in   synchronous active-high reset, highest priority
//   valid        in   'in' carries a stream bit this cycle
//   in           in   serial data bit
//   cfg_load     in   latch cfg_*, clear history and counter
//   cfg_pattern  in   pattern, right-aligned, bit len-1 received first
//   cfg_len      in   pattern length (0 = never match, >MAX_LEN clamped)
//   cfg_overlap  in   1 = overlapping detection
//   out          out  registered match pulse
//   match_count  out  saturating count of out pulses
//   count_sat    out  sticky saturation flag
// ---------------------------------------------------------------------------
module pattern_detector_param
  import patdet_pkg::*;
#(
  parameter int                 MAX_LEN     = PKG_MAX_LEN,
  parameter int                 CNT_W       = 16,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(PKG_DEF_PATTERN),
  parameter int                 DEF_LEN     = PKG_DEF_LEN,
  parameter logic               DEF_OVERLAP = 1'b1,
  localparam int                LEN_W       = lenw(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid,
  input  logic               in,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               out,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  ovl_mode_e          r_ovl;
  logic               r_out;

  logic [MAX_LEN-1:0] w_histNext;
  logic [LEN_W-1:0]   w_fillNext;
  logic [MAX_LEN-1:0] w_mask;
  logic [LEN_W-1:0]   w_cfgLen;
  logic               w_match;

  // Candidate next history/fill for a valid bit. The fill counter tells us
  // how many genuine stream bits the history holds, so zeros left over from
  // reset or a config load can never complete a pattern. A zero length
  // would otherwise match everything through an empty mask, so it is
  // excluded explicitly.
  always_comb begin
    w_histNext = {r_hist[MAX_LEN-2:0], in};
    w_fillNext = (r_fill == LEN_MAX) ? r_fill : r_fill + 1'b1;
    w_mask     = MAX_LEN'(len_mask(int'(r_len)));
    w_match    = (r_len != '0) && (w_fillNext >= r_len) &&
                 (((w_histNext ^ r_pat) & w_mask) == '0);
    w_cfgLen   = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
  end

  // Main state. Reset beats a config load, and a config load beats a
  // coincident valid bit (that bit is dropped). In non-overlap mode a match
  // empties the fill count so the next match needs a full fresh pattern;
  // the history itself is kept since fill alone gates matching. Idle cycles
  // freeze history and fill so gaps never break a partial match.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hist <= '0;
      r_fill <= '0;
      r_pat  <= DEF_PATTERN;
      r_len  <= LEN_W'(DEF_LEN);
      r_ovl  <= DEF_OVERLAP ? MODE_OVL : MODE_NONOVL;
      r_out  <= 1'b0;
    end else if (cfg_load) begin
      r_hist <= '0;
      r_fill <= '0;
      r_pat  <= cfg_pattern;
      r_len  <= w_cfgLen;
      r_ovl  <= cfg_overlap ? MODE_OVL : MODE_NONOVL;
      r_out  <= 1'b0;
    end else if (valid) begin
      r_hist <= w_histNext;
      r_fill <= (w_match && (r_ovl == MODE_NONOVL)) ? '0 : w_fillNext;
      r_out  <= w_match;
    end else begin
      r_out  <= 1'b0;
    end
  end

  assign out = r_out;

`ifdef PATDET_COUNTER_EN
  // The counter watches the registered pulse, so it trails out by a cycle.
  patdet_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_satCnt (
    .clk     (clk),
    .rst     (rst),
    .i_clear (cfg_load),
    .i_inc   (r_out),
    .o_count (match_count),
    .o_sat   (count_sat)
  );
`else
  assign match_count = '0;
  assign count_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_pattern_detector_param.sv
// ---------------------------------------------------------------------------
// tb_pattern_detector_param
// Directed bench for pattern_detector_param. Each driven cycle pushes its
// hand-computed expected response into a queue; a separate monitor pops
// one entry after every clock edge and compares out, and where requested
// match_count and count_sat.
// Honours PATDET_COUNTER_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_pattern_detector_param;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = $clog2(MAX_LEN) + 1;

  logic               clk;
  logic               rst;
  logic               valid;
  logic               in;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               out;
  logic [CNT_W-1:0]   match_count;
  logic               count_sat;

  typedef struct {
    string tag;
    logic  expOut;
    int    expCnt;
    logic  expSat;
  } exp_t;

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;

  pattern_detector_param #(
    .MAX_LEN (MAX_LEN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .valid       (valid),
    .in          (in),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .out         (out),
    .match_count (match_count),
    .count_sat   (count_sat)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison; prints a FAIL line when actual differs from expected.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Drives one clock cycle of inputs at the falling edge and queues the
  // response expected just after the next rising edge. expCnt < 0 means
  // the counter outputs are not checked for this cycle; with the counter
  // compiled out the expected count and flag are always zero.
  task automatic applyStimulus(input logic iRst, input logic iLoad,
                               input logic iValid, input logic iBit,
                               input logic expOut, input int expCnt,
                               input string tag);
    exp_t e;
    @(negedge clk);
    rst      = iRst;
    cfg_load = iLoad;
    valid    = iValid;
    in       = iBit;
    e.tag    = tag;
    e.expOut = expOut;
`ifdef PATDET_COUNTER_EN
    e.expCnt = expCnt;
    e.expSat = (expCnt == 3);
`else
    e.expCnt = (expCnt < 0) ? -1 : 0;
    e.expSat = 1'b0;
`endif
    expQ.push_back(e);
    @(posedge clk);
  endtask

  // Feeds n bits MSB-first; pulses marks which bits should raise out.
  task automatic sendStream(input logic [7:0] bits, input int n,
                            input logic [7:0] pulses, input string tag);
    logic [7:0] b;
    logic [7:0] p;
    b = bits;
    p = pulses;
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, b[n-1-i], p[n-1-i], -1, tag);
    end
  endtask

  task automatic setCfg(input logic [7:0] pat, input logic [3:0] len,
                        input logic ovl);
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
  endtask

  // Monitor: one expected entry per driven cycle, checked just after the
  // rising edge that produced it.
  always @(posedge clk) begin
    #1;
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      checkOutput({e.tag, "_out"}, {31'd0, out}, {31'd0, e.expOut});
      if (e.expCnt >= 0) begin
        checkOutput({e.tag, "_count"}, {30'd0, match_count}, e.expCnt);
        checkOutput({e.tag, "_sat"}, {31'd0, count_sat}, {31'd0, e.expSat});
      end
    end
  end

  initial begin
    rst      = 1'b1;
    valid    = 1'b0;
    in       = 1'b0;
    cfg_load = 1'b0;
    setCfg(8'h00, 4'd0, 1'b0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, "reset0");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, "reset1");

    // Default 10010 overlapping: pulses after bits 5 and 8.
    sendStream(8'b1001_0010, 8, 8'b0000_1001, "ovl");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, "ovl_idle");

    // Same pattern non-overlapping: only the pulse after bit 5.
    setCfg(8'b0001_0010, 4'd5, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, "nonovl_load");
    sendStream(8'b1001_0010, 8, 8'b0000_1000, "nonovl");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, "nonovl_idle");

    // Default config restored by reset; idle gaps with a toggling input.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, "gap_reset");
    begin
      logic [4:0] gapBits;
      gapBits = 5'b10010;
      for (int i = 0; i < 5; i++) begin
        applyStimulus(1'b0, 1'b0, 1'b1, gapBits[4-i], (i == 4), -1, "gap_bit");
        applyStimulus(1'b0, 1'b0, 1'b0, ~gapBits[4-i], 1'b0,
                      (i == 4) ? 1 : -1, "gap_idle");
      end
    end

    // Full 8-bit pattern.
    setCfg(8'b1011_0110, 4'd8, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, "len8_load");
    sendStream(8'b1011_0110, 8, 8'b0000_0001, "len8");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, "len8_idle");

    // Reload after four bits discards the partial match.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, "reload_load");
    sendStream(8'b0000_1011, 4, 8'h00, "reload_a");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, "reload_mid");
    sendStream(8'b0000_0110, 4, 8'h00, "reload_b");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, "reload_idle");

    // A valid bit coincident with the load is dropped, so seven more bits
    // cannot complete the pattern.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, "drop_load");
    sendStream(8'b0011_0110, 7, 8'h00, "drop");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, "drop_idle");

    // len 1 back-to-back pulses and counter saturation at 3.
    setCfg(8'h01, 4'd1, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, "sat_load");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0, "sat_b1");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1, "sat_b2");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2, "sat_b3");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3, "sat_b4");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3, "sat_b5");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, "sat_idle");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, "sat_clear");

    // len 1 back-to-back in non-overlap mode.
    setCfg(8'h01, 4'd1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, "len1no_load");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0, "len1no_b1");
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1, "len1no_b2");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, "len1no_idle");

    // Reset mid-pattern: the straddling 10010 is not detected.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, "midrst_init");
    sendStream(8'b0000_1001, 4, 8'h00, "midrst_a");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, "midrst_rst");
    sendStream(8'b0000_0000, 1, 8'h00, "midrst_b");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, "midrst_idle");

    // Zero length never matches, whatever the stream.
    setCfg(8'h00, 4'd0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, "len0_load");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, -1,
                    "len0");
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, "len0_idle");

    // Oversized length clamps to MAX_LEN.
    setCfg(8'b1011_0110, 4'd15, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, "clamp_load");
    sendStream(8'b1011_0110, 8, 8'b0000_0001, "clamp");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, "clamp_idle");

    // Let the monitor drain, with a bounded wait.
    for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
      @(posedge clk);
    end
    #2;
    if (expQ.size() > 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
